// File: rtl/tx_engine_pkg.sv
// -----------------------------------------------------------------------------
// tx_engine_pkg
// Definitions shared by both ends of the UART link (Tx and Rx engines):
//   FRAME_BITS  - bit times per frame (start + data + parity + stop fill)
//   K_W         - width of the baud divisor k
//   BIT_CNT_W   - width of the per-frame bit counter
//   uart_state_e- IDLE/SEND state encoding
//   build_frame - assembles the 11-bit frame, bit 0 goes on the line first
// -----------------------------------------------------------------------------
package tx_engine_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned K_W        = 19;
  localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } uart_state_e;

  // Start bit at position 0, data LSB first, optional parity directly after the
  // last data bit, and every remaining position left at 1 so the stop-bit count
  // falls out of the format automatically (8P:1, 8N/7P:2, 7N:3).
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [7:0] data,
    input logic       eight,
    input logic       p_en,
    input logic       ohel
  );
    logic [FRAME_BITS-1:0] f;
    logic                  par;
    f    = '1;
    f[0] = 1'b0;
    if (eight) begin
      f[8:1] = data;
      par    = ^data;
    end else begin
      f[7:1] = data[6:0];
      par    = ^data[6:0];
    end
    // ohel=1 (odd) inverts the even-parity bit
    if (p_en) begin
      if (eight) f[9] = par ^ ohel;
      else       f[8] = par ^ ohel;
    end
    return f;
  endfunction

endpackage

// File: rtl/tx_engine_bit_timer.sv
// -----------------------------------------------------------------------------
// tx_bit_timer
// Bit-time generator for the Tx engine. Counts 0..max(k,1)-1 while run is high
// and pulses btu on the terminal count; held at zero while run is low.
// Ports:
//   clk  in        system clock
//   rst  in        asynchronous active-low reset
//   k    in  K_W   clocks per bit time (0 behaves as 1)
//   run  in        count enable; counter clears when low
//   btu  out       one-cycle pulse at the end of each bit time
// -----------------------------------------------------------------------------
module tx_bit_timer
  import tx_engine_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [K_W-1:0] k,
  input  logic           run,
  output logic           btu
);

  logic [K_W-1:0] k_eff;
  logic [K_W-1:0] cnt_q;
  logic [K_W-1:0] cnt_d;

  assign k_eff = (k == '0) ? K_W'(1) : k;

  // >= rather than == so a k lowered mid-frame never lets the counter run
  // past the new terminal count and wrap.
  assign btu = run && (cnt_q >= (k_eff - K_W'(1)));

  always_comb begin
    cnt_d = cnt_q + K_W'(1);
    if (!run || btu) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tx_engine.sv
// -----------------------------------------------------------------------------
// tx_engine
// UART transmit engine. On an accepted load the byte is framed (start, 7/8 data
// bits LSB first, optional parity, stop fill to 11 bits) and shifted out on tx,
// each bit lasting max(k,1) clocks.
// Ports:
//   clk      in        system clock
//   rst      in        asynchronous active-low reset
//   k        in  K_W   clocks per bit time (0 behaves as 1)
//   eight    in        1 = 8 data bits, 0 = 7 data bits
//   p_en     in        parity bit enable
//   ohel     in        parity sense, 0 = even, 1 = odd
//   load     in        send request, honored only while tx_rdy = 1
//   data     in  8     byte to transmit
//   tx       out       serial line, idle high, registered
//   tx_rdy   out       engine idle
//   tx_done  out       one-cycle pulse at end of frame
// -----------------------------------------------------------------------------
module tx_engine
  import tx_engine_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [K_W-1:0] k,
  input  logic           eight,
  input  logic           p_en,
  input  logic           ohel,
  input  logic           load,
  input  logic [7:0]     data,
  output logic           tx,
  output logic           tx_rdy,
  output logic           tx_done
);

  uart_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0]  sr_q, sr_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   done_q, done_d;
  logic                   btu;
  logic                   last_bit;

  tx_bit_timer u_bit_timer (
    .clk (clk),
    .rst (rst),
    .k   (k),
    .run (state_q == ST_SEND),
    .btu (btu)
  );

  assign last_bit = (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load)            state_d = ST_SEND;
      ST_SEND: if (btu && last_bit) state_d = ST_IDLE;
      default:                      state_d = ST_IDLE;
    endcase
  end

  // Frame datapath: the shift register fills with 1s as it empties, so it is
  // all-ones again when the frame ends and tx idles high without extra muxing.
  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (load) begin
        sr_d      = build_frame(data, eight, p_en, ohel);
        bit_cnt_d = '0;
      end
    end else if (btu) begin
      sr_d      = {1'b1, sr_q[FRAME_BITS-1:1]};
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
      if (last_bit) begin
        bit_cnt_d = '0;
        done_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q      <= '1;
      bit_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      done_q    <= done_d;
    end
  end

  // Outputs
  always_comb begin
    tx      = sr_q[0];
    tx_rdy  = (state_q == ST_IDLE);
    tx_done = done_q;
  end

endmodule

// File: tb/tb_tx_engine.sv
module tb_tx_engine;
  import tx_engine_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic [K_W-1:0] k;
  logic           eight, p_en, ohel, load;
  logic [7:0]     data;
  logic           tx, tx_rdy, tx_done;

  tx_engine dut (
    .clk     (clk),
    .rst     (rst),
    .k       (k),
    .eight   (eight),
    .p_en    (p_en),
    .ohel    (ohel),
    .load    (load),
    .data    (data),
    .tx      (tx),
    .tx_rdy  (tx_rdy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] bits;
    int          kk;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_active = 1'b0;
  int   frames_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Drive a load in the current (ready) cycle, then scramble the inputs so any
  // late sampling by the DUT would corrupt the frame.
  task automatic send(input int kv, input logic [7:0] d, input logic e,
                      input logic pe, input logic oh, input logic [10:0] expb);
    exp_t x;
    k     = K_W'(kv);
    data  = d;
    eight = e;
    p_en  = pe;
    ohel  = oh;
    load  = 1'b1;
    x.bits = expb;
    x.kk   = (kv == 0) ? 1 : kv;
    exp_q.push_back(x);
    @(posedge clk); #1;
    load  = 1'b0;
    data  = ~d;
    eight = ~e;
    p_en  = ~pe;
    ohel  = ~oh;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!tx_rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", 32'(tx_rdy), 32'd1);
  endtask

  // Monitor / scoreboard: a falling tx_rdy marks a frame start; every cycle of
  // the frame is compared with the queued expected bit, then the end-of-frame
  // handshake is checked.
  initial begin
    exp_t cur;
    int   cyc;
    logic prev_rdy;
    cyc      = 0;
    prev_rdy = 1'b1;
    cur.bits = '1;
    cur.kk   = 1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_active = 1'b0;
        prev_rdy   = 1'b1;
      end else begin
        if (!mon_active && prev_rdy && !tx_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
          end else begin
            cur        = exp_q.pop_front();
            mon_active = 1'b1;
            cyc        = 0;
          end
        end
        if (mon_active) begin
          if (cyc < 11 * cur.kk) begin
            chk($sformatf("bit%0d_cyc%0d", cyc / cur.kk, cyc), 32'(tx), 32'(cur.bits[cyc / cur.kk]));
            chk($sformatf("busy_cyc%0d", cyc), 32'({tx_rdy, tx_done}), 32'd0);
          end else begin
            chk("end_tx_rdy_done", 32'({tx, tx_rdy, tx_done}), 32'b111);
            frames_seen++;
            $display("frame %0d: bits=%b k=%0d length=%0d clocks", frames_seen, cur.bits, cur.kk, cyc);
            mon_active = 1'b0;
          end
          cyc++;
        end else begin
          chk("idle_no_done", 32'(tx_done), 32'd0);
        end
        prev_rdy = tx_rdy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0; k = K_W'(4); data = 8'h00; eight = 1'b1; p_en = 1'b0; ohel = 1'b0; load = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_state", 32'({tx, tx_rdy, tx_done}), 32'b110);
    rst = 1'b1;
    @(posedge clk); #1;

    send(4, 8'h55, 1'b1, 1'b1, 1'b0, 11'b10010101010); wait_idle();
    send(3, 8'hC1, 1'b0, 1'b0, 1'b0, 11'b11110000010); wait_idle();
    send(2, 8'h01, 1'b1, 1'b1, 1'b1, 11'b10000000010); wait_idle();
    send(2, 8'h01, 1'b1, 1'b1, 1'b0, 11'b11000000010); wait_idle();
    send(0, 8'hA5, 1'b1, 1'b0, 1'b0, 11'b11101001010); wait_idle();
    send(1, 8'hA5, 1'b0, 1'b1, 1'b0, 11'b11101001010); wait_idle();

    // Loads during a frame are ignored; a load held at tx_rdy rise starts at once.
    send(4, 8'h55, 1'b1, 1'b1, 1'b0, 11'b10010101010);
    repeat (4) @(posedge clk); #1;
    load = 1'b1; data = 8'hFF;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (14) @(posedge clk); #1;
    load = 1'b1; data = 8'h00;
    @(posedge clk); #1;
    load = 1'b0;
    data = 8'hC1; eight = 1'b0; p_en = 1'b0; ohel = 1'b0; load = 1'b1;
    exp_q.push_back('{11'b11110000010, 4});
    n = 0;
    while (!tx_rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_wait_rdy", 32'(tx_rdy), 32'd1);
    @(posedge clk); #1;
    chk("b2b_start_same_edge", 32'({tx_rdy, tx}), 32'b00);
    load = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a frame.
    send(4, 8'h55, 1'b1, 1'b1, 1'b0, 11'b10010101010);
    repeat (9) @(posedge clk); #1;
    #1 rst = 1'b0;
    #1;
    chk("midframe_reset", 32'({tx, tx_rdy, tx_done}), 32'b110);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("after_reset_idle", 32'({tx, tx_rdy}), 32'b11);
    send(3, 8'hC1, 1'b0, 1'b0, 1'b0, 11'b11110000010); wait_idle();

    repeat (5) @(posedge clk); #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("monitor_idle", 32'(mon_active), 32'd0);
    chk("frames_seen", 32'(frames_seen), 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
